mem_wb_stage: RTL and testbench

Memory-access stage plus W pipeline register of the Y86-64 five-stage pipeline. It consumes the M register outputs (stat, icode, ifun, Cnd, valE, valA, dstE, dstM), performs the data-memory read or write, and produces the memory-stage status and loaded value. These same-cycle values feed the forwarding and hazard logic. On the next clock edge it captures the results into the W register that drives writeback.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_dmem.sv | 52 +++++
 rtl/mem_wb_stage.sv | 81 ++++++++
 tb/tb_mem_wb_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and memory-access decode helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

  // Stack pops read through the old stack pointer carried in valA.
  function automatic logic addr_from_val_a(input logic [3:0] icode);
    return (icode == IPOPQ) || (icode == IRET);
  endfunction

endpackage

// File: rtl/y86_dmem.sv
// Byte-addressed data memory: asynchronous 8-byte little-endian read, synchronous 8-byte write,
// bounds error generation; DMEM_ALIGN_CHECK_EN additionally flags misaligned accesses.
module y86_dmem #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        access,
  input  logic [63:0] addr,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        error
);

  localparam int AW = $clog2(DMEM_BYTES);
  localparam logic [63:0] LAST_BASE = 64'(DMEM_BYTES - 8);

  logic [7:0]    mem [DMEM_BYTES];
  logic [AW-1:0] base;
  logic          misaligned;

  assign base = addr[AW-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (addr[2:0] != 3'd0);
`else
  assign misaligned = 1'b0;
`endif

  // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
  assign error = access && ((addr > LAST_BASE) || misaligned);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rdata = '0;
    if (!error) begin
      for (int i = 0; i < 8; i++) begin
        rdata[8*i +: 8] = mem[base + AW'(i)];
      end
    end
  end

  // NOTE: the byte array has no reset; contents survive rst_n and a reset would also block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Y86-64 memory-access stage and W pipeline register. Optional macro: DMEM_ALIGN_CHECK_EN
// (misaligned data accesses report ADR).
module mem_wb_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_stall,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_Ins_Code,
  input  logic [3:0]  M_Ins_fun,
  input  logic        M_cnd,
  input  logic [63:0] M_Value_E,
  input  logic [63:0] M_value_A,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_Ins_Code,
  output logic [63:0] W_Value_E,
  output logic [63:0] W_Value_M,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  logic        mem_read;
  logic        mem_write;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        dmem_error;
  logic        unused_inputs;

  // ifun and Cnd were fully consumed upstream; cmov suppression is already folded into M_dstE.
  assign unused_inputs = ^{M_Ins_fun, M_cnd};

  assign mem_read  = is_mem_read(M_Ins_Code);
  assign mem_write = is_mem_write(M_Ins_Code);
  assign mem_addr  = addr_from_val_a(M_Ins_Code) ? M_value_A : M_Value_E;

  // Bubbles, halted/illegal instructions and a reset in progress must never disturb memory.
  assign mem_we = mem_write && !dmem_error && (M_stat == SAOK) && rst_n;

  y86_dmem #(
    .DMEM_BYTES (DMEM_BYTES)
  ) u_dmem (
    .clk    (clk),
    .access (mem_read || mem_write),
    .addr   (mem_addr),
    .we     (mem_we),
    .wdata  (M_value_A),
    .rdata  (mem_rdata),
    .error  (dmem_error)
  );

  assign m_stat = dmem_error ? SADR : M_stat;
  assign m_valM = (mem_read && !dmem_error) ? mem_rdata : 64'd0;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat     <= SBUB;
      W_Ins_Code <= INOP;
      W_Value_E  <= '0;
      W_Value_M  <= '0;
      W_dstE     <= RNONE;
      W_dstM     <= RNONE;
    end else if (!W_stall) begin
      W_stat     <= m_stat;
      W_Ins_Code <= M_Ins_Code;
      W_Value_E  <= M_Value_E;
      W_Value_M  <= m_valM;
      W_dstE     <= M_dstE;
      W_dstM     <= M_dstM;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected per-cycle outputs, negedge monitor pops and compares.
module tb_mem_wb_stage;

  localparam int DMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        W_stall = 1'b0;
  logic [2:0]  M_stat = 3'd1;
  logic [3:0]  M_Ins_Code = 4'h4;
  logic [3:0]  M_Ins_fun = 4'h0;
  logic        M_cnd = 1'b0;
  logic [63:0] M_Value_E = 64'h300;
  logic [63:0] M_value_A = 64'hDEAD;
  logic [3:0]  M_dstE = 4'hF;
  logic [3:0]  M_dstM = 4'hF;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic [2:0]  W_stat;
  logic [3:0]  W_Ins_Code;
  logic [63:0] W_Value_E;
  logic [63:0] W_Value_M;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  mem_wb_stage #(.DMEM_BYTES(DMEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .W_stall    (W_stall),
    .M_stat     (M_stat),
    .M_Ins_Code (M_Ins_Code),
    .M_Ins_fun  (M_Ins_fun),
    .M_cnd      (M_cnd),
    .M_Value_E  (M_Value_E),
    .M_value_A  (M_value_A),
    .M_dstE     (M_dstE),
    .M_dstM     (M_dstM),
    .m_stat     (m_stat),
    .m_valM     (m_valM),
    .W_stat     (W_stat),
    .W_Ins_Code (W_Ins_Code),
    .W_Value_E  (W_Value_E),
    .W_Value_M  (W_Value_M),
    .W_dstE     (W_dstE),
    .W_dstM     (W_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  m_stat;
    logic [63:0] m_valM;
    logic [2:0]  w_stat;
    logic [3:0]  w_icode;
    logic [63:0] w_vale;
    logic [63:0] w_valm;
    logic [3:0]  w_dste;
    logic [3:0]  w_dstm;
  } exp_t;

  exp_t sb[$];
  exp_t wm;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        check("sb_late", 64'(cyc), 64'(e.cyc));
      end else begin
        check("m_stat",     64'(m_stat),     64'(e.m_stat));
        check("m_valM",     m_valM,          e.m_valM);
        check("W_stat",     64'(W_stat),     64'(e.w_stat));
        check("W_Ins_Code", 64'(W_Ins_Code), 64'(e.w_icode));
        check("W_Value_E",  W_Value_E,       e.w_vale);
        check("W_Value_M",  W_Value_M,       e.w_valm);
        check("W_dstE",     64'(W_dstE),     64'(e.w_dste));
        check("W_dstM",     64'(W_dstM),     64'(e.w_dstm));
      end
    end
  end

  function automatic void w_reset();
    wm.w_stat  = 3'd0;
    wm.w_icode = 4'h1;
    wm.w_vale  = 64'd0;
    wm.w_valm  = 64'd0;
    wm.w_dste  = 4'hF;
    wm.w_dstm  = 4'hF;
  endfunction

  // One pipeline cycle: drive M inputs, push expected outputs for this cycle, advance the W model.
  task automatic step(input bit rst, input bit stall, input logic [2:0] stat, input logic [3:0] icode,
                      input logic [63:0] vale, input logic [63:0] vala,
                      input logic [3:0] dste, input logic [3:0] dstm,
                      input logic [2:0] exp_mstat, input logic [63:0] exp_valm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = !rst;
    W_stall    = stall;
    M_stat     = stat;
    M_Ins_Code = icode;
    M_Ins_fun  = 4'h0;
    M_cnd      = 1'b1;
    M_Value_E  = vale;
    M_value_A  = vala;
    M_dstE     = dste;
    M_dstM     = dstm;
    if (rst) w_reset();
    e = wm;
    e.cyc    = cyc;
    e.m_stat = exp_mstat;
    e.m_valM = exp_valm;
    sb.push_back(e);
    if (!rst && !stall) begin
      wm.w_stat  = exp_mstat;
      wm.w_icode = icode;
      wm.w_vale  = vale;
      wm.w_valm  = exp_valm;
      wm.w_dste  = dste;
      wm.w_dstm  = dstm;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w_reset();
    // Reset with an otherwise-legal store on the inputs: W held at reset values, store blocked.
    step(1, 0, 3'd1, 4'h4, 64'h300, 64'hDEAD, 4'h3, 4'h4, 3'd1, 64'd0);
    step(1, 0, 3'd1, 4'h4, 64'h300, 64'hDEAD, 4'h3, 4'h4, 3'd1, 64'd0);
    // Store then load at 0x40.
    step(0, 0, 3'd1, 4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF, 3'd1, 64'd0);
    step(0, 0, 3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h2, 3'd1, 64'h1122334455667788);
    // POPQ addresses through valA.
    step(0, 0, 3'd1, 4'h4, 64'h100, 64'd5, 4'hF, 4'hF, 3'd1, 64'd0);
    step(0, 0, 3'd1, 4'hB, 64'h108, 64'h100, 4'h4, 4'h0, 3'd1, 64'd5);
    // Last legal base, then out-of-range push must leave it intact.
    step(0, 0, 3'd1, 4'h4, 64'(DMEM_BYTES - 8), 64'h0123456789ABCDEF, 4'hF, 4'hF, 3'd1, 64'd0);
    step(0, 0, 3'd1, 4'hA, 64'(DMEM_BYTES - 4), 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 4'hF, 3'd3, 64'd0);
    step(0, 0, 3'd1, 4'h5, 64'(DMEM_BYTES - 8), 64'h0, 4'hF, 4'h1, 3'd1, 64'h0123456789ABCDEF);
    step(0, 0, 3'd1, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h1, 3'd3, 64'd0);
    // Bubble store has no effect; stall holds W while a store still commits.
    step(0, 0, 3'd0, 4'h4, 64'h40, 64'hBAD, 4'hF, 4'hF, 3'd0, 64'd0);
    step(0, 1, 3'd1, 4'h4, 64'h48, 64'h77, 4'hF, 4'hF, 3'd1, 64'd0);
    step(0, 1, 3'd1, 4'h5, 64'h48, 64'h0, 4'hF, 4'h5, 3'd1, 64'h77);
    step(0, 0, 3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h6, 3'd1, 64'h1122334455667788);
    // Store under INS status is suppressed.
    step(0, 0, 3'd4, 4'h4, 64'h40, 64'h99, 4'hF, 4'hF, 3'd4, 64'd0);
    step(0, 0, 3'd1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h6, 3'd1, 64'h1122334455667788);
    // Misaligned load.
`ifdef DMEM_ALIGN_CHECK_EN
    step(0, 0, 3'd1, 4'h5, 64'h43, 64'h0, 4'hF, 4'h7, 3'd3, 64'd0);
`else
    step(0, 0, 3'd1, 4'h5, 64'h43, 64'h0, 4'hF, 4'h7, 3'd1, 64'h0000771122334455);
`endif
    // Non-memory op passes through with zero load data.
    step(0, 0, 3'd1, 4'h6, 64'h1234, 64'h55, 4'h3, 4'hF, 3'd1, 64'd0);
    // Mid-run reset blocks a store and keeps memory.
    step(0, 0, 3'd1, 4'h4, 64'h200, 64'hCAFE, 4'hF, 4'hF, 3'd1, 64'd0);
    step(1, 0, 3'd1, 4'h4, 64'h200, 64'hBEEF, 4'h2, 4'h3, 3'd1, 64'd0);
    step(1, 0, 3'd1, 4'h4, 64'h200, 64'hBEEF, 4'h2, 4'h3, 3'd1, 64'd0);
    step(0, 0, 3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h8, 3'd1, 64'hCAFE);
    step(0, 0, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 64'd0);
    step(0, 0, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 3'd1, 64'd0);
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
